// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, line/frame measurements and a lock state from an
// HSYNC/VSYNC pair sampled on the same pixel clock as the timing source.
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int H_PULSE     = 96,
    parameter int H_BACK      = 48,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_PULSE     = 2,
    parameter int V_BACK      = 33,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       vga_hs,
    input  logic       vga_vs,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       pix_valid,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err,
    output logic [9:0] h_total_meas,
    output logic [9:0] v_total_meas
);

    localparam logic [10:0] H_TOT_L = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT_L = 11'(V_TOTAL);
    localparam logic [10:0] X_START = 11'(H_PULSE + H_BACK);
    localparam logic [10:0] X_END   = 11'(H_PULSE + H_BACK + H_ACTIVE);
    localparam logic [10:0] Y_START = 11'(V_PULSE + V_BACK);
    localparam logic [10:0] Y_END   = 11'(V_PULSE + V_BACK + V_ACTIVE);
    localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t     state_q, state_d;
    logic       hs_dly_q, hs_dly_d, vs_dly_q, vs_dly_d;
    logic       vs_fell_q, vs_fell_d;
    logic [9:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d;
    logic [3:0] good_cnt_q, good_cnt_d;
    logic       frame_bad_q, frame_bad_d;
    logic       seen_line_q, seen_line_d, seen_frame_q, seen_frame_d;
    logic [9:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic       pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
    logic       locked_q, locked_d, sync_err_q, sync_err_d;
    logic [9:0] h_meas_q, h_meas_d, v_meas_q, v_meas_d;

    logic        line_start, vs_fall, frame_start_i, x_sat, line_bad, frame_len_bad, in_window;
    logic [10:0] x_inc, y_inc;

    always_comb begin
        line_start    = hs_dly_q & ~vga_hs;
        vs_fall       = vs_dly_q & ~vga_vs;
        frame_start_i = line_start & (vs_fell_q | vs_fall);
        x_inc         = {1'b0, x_pos_q} + 11'd1;
        y_inc         = {1'b0, y_pos_q} + 11'd1;
        // Counter stuck at its ceiling with no HSYNC arriving: the source is gone.
        x_sat         = (x_pos_q == 10'h3FF) & ~line_start;
        line_bad      = line_start & seen_line_q & (x_inc != H_TOT_L);
        frame_len_bad = (y_inc != V_TOT_L);

        hs_dly_d     = vga_hs;
        vs_dly_d     = vga_vs;
        vs_fell_d    = line_start ? 1'b0 : (vs_fell_q | vs_fall);
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        frame_bad_d  = frame_bad_q;
        seen_line_d  = seen_line_q | line_start;
        seen_frame_d = seen_frame_q | frame_start_i;
        h_meas_d     = h_meas_q;
        v_meas_d     = v_meas_q;
        sync_err_d   = 1'b0;

        if (line_start)
            x_pos_d = 10'd0;
        else if (x_pos_q == 10'h3FF)
            x_pos_d = x_pos_q;
        else
            x_pos_d = x_inc[9:0];

        if (frame_start_i)
            y_pos_d = 10'd0;
        else if (line_start && y_pos_q != 10'h3FF)
            y_pos_d = y_inc[9:0];
        else
            y_pos_d = y_pos_q;

        if (line_start && seen_line_q)
            h_meas_d = x_inc[9:0];
        if (frame_start_i && seen_frame_q)
            v_meas_d = y_inc[9:0];

        case (state_q)
            SEARCH: begin
                if (frame_start_i) begin
                    state_d     = CHECK;
                    good_cnt_d  = 4'd0;
                    frame_bad_d = 1'b0;
                end
            end
            CHECK: begin
                if (frame_start_i) begin
                    frame_bad_d = 1'b0;
                    if (frame_bad_q | line_bad | frame_len_bad) begin
                        good_cnt_d = 4'd0;
                    end else begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        if (good_cnt_q + 4'd1 == LOCK_N)
                            state_d = LOCKED;
                    end
                end else if (line_bad) begin
                    frame_bad_d = 1'b1;
                end
            end
            LOCKED: begin
                if (line_bad || (frame_start_i && frame_len_bad)) begin
                    state_d     = CHECK;
                    good_cnt_d  = 4'd0;
                    sync_err_d  = 1'b1;
                    // A mid-frame failure taints the frame still in progress.
                    frame_bad_d = line_bad & ~frame_start_i;
                end
            end
            default: state_d = SEARCH;
        endcase

        if (x_sat) begin
            state_d      = SEARCH;
            sync_err_d   = (state_q == LOCKED);
            seen_line_d  = 1'b0;
            seen_frame_d = 1'b0;
            good_cnt_d   = 4'd0;
            frame_bad_d  = 1'b0;
        end

        locked_d      = (state_q == LOCKED);
        frame_start_d = frame_start_i;
        in_window     = ({1'b0, x_pos_d} >= X_START) && ({1'b0, x_pos_d} < X_END) &&
                        ({1'b0, y_pos_d} >= Y_START) && ({1'b0, y_pos_d} < Y_END);
        pix_valid_d   = in_window & locked_d;
        pix_x_d       = pix_valid_d ? (x_pos_d - X_START[9:0]) : 10'd0;
        pix_y_d       = pix_valid_d ? (y_pos_d - Y_START[9:0]) : 10'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= SEARCH;
            hs_dly_q      <= 1'b0;
            vs_dly_q      <= 1'b0;
            vs_fell_q     <= 1'b0;
            x_pos_q       <= 10'd0;
            y_pos_q       <= 10'd0;
            good_cnt_q    <= 4'd0;
            frame_bad_q   <= 1'b0;
            seen_line_q   <= 1'b0;
            seen_frame_q  <= 1'b0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
            h_meas_q      <= 10'd0;
            v_meas_q      <= 10'd0;
        end else begin
            state_q       <= state_d;
            hs_dly_q      <= hs_dly_d;
            vs_dly_q      <= vs_dly_d;
            vs_fell_q     <= vs_fell_d;
            x_pos_q       <= x_pos_d;
            y_pos_q       <= y_pos_d;
            good_cnt_q    <= good_cnt_d;
            frame_bad_q   <= frame_bad_d;
            seen_line_q   <= seen_line_d;
            seen_frame_q  <= seen_frame_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            sync_err_q    <= sync_err_d;
            h_meas_q      <= h_meas_d;
            v_meas_q      <= v_meas_d;
        end
    end

    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign pix_valid    = pix_valid_q;
    assign frame_start  = frame_start_q;
    assign locked       = locked_q;
    assign sync_err     = sync_err_q;
    assign h_total_meas = h_meas_q;
    assign v_total_meas = v_meas_q;

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing generator; consumes HSYNC/VSYNC (active low) sampled on the pixel clock and recovers pixel coordinates and an active-video qualifier.
- Measures line and frame lengths, runs a lock FSM against the nominal 640x480 timing, and flags sync errors.
- Sits in loopback/capture paths and in self-check benches behind any VGA timing source on the same clock.

Parameters:
- H_TOTAL, 800, clocks per line
- H_PULSE, 96, HSYNC low width
- H_BACK, 48, back porch; active start column = H_PULSE+H_BACK
- H_ACTIVE, 640, active columns
- V_TOTAL, 525, lines per frame
- V_PULSE, 2, VSYNC low width in lines
- V_BACK, 33, back porch lines
- V_ACTIVE, 480, active lines
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..15)

Ports:
- clock  in  1  pixel clock; the sync source runs on this same clock
- reset  in  1  synchronous, active-high
- vga_hs  in  1  HSYNC, active low
- vga_vs  in  1  VSYNC, active low
- pix_x  out  10  active column, 0..H_ACTIVE-1; 0 when pix_valid=0
- pix_y  out  10  active row, 0..V_ACTIVE-1; 0 when pix_valid=0
- pix_valid  out  1  sample is inside the active window AND locked
- frame_start  out  1  one-cycle pulse on each detected frame start
- locked  out  1  lock FSM is in LOCKED
- sync_err  out  1  one-cycle pulse when lock is lost
- h_total_meas  out  10  length of the last complete line
- v_total_meas  out  10  length of the last complete frame, in lines

Behaviour:
- Reset:
  - All outputs are 0.
  - x_pos, y_pos = 0; FSM = SEARCH; good_cnt = 0; frame_bad = 0.
  - seen_line = 0, seen_frame = 0.
  - Reset mid-frame discards all history.
- Edge detect:
  - hs_d and vs_d are one-cycle delayed copies of the inputs.
  - line_start = hs_d & ~vga_hs.
  - vs_fell is set by ~vga_vs & vs_d and held until the next line_start.
  - frame_start_i = line_start & (vs_fell OR coincident VSYNC fall).
- Position counters (10-bit registers, saturate at 1023):
  - line_start: x_pos <= 0; otherwise x_pos <= x_pos+1.
  - frame_start_i: y_pos <= 0; else on line_start: y_pos <= y_pos+1.
  - During cycle t, x_pos/y_pos describe the sample taken at cycle t-1, so output latency is 1 clock.
- Measurement:
  - On line_start with seen_line=1: h_total_meas <= x_pos+1.
  - On frame_start_i with seen_frame=1: v_total_meas <= y_pos+1.
  - seen_line is set on the first line_start; seen_frame on the first frame_start_i.
- Active window (inclusive start, exclusive end):
  - x_pos in [H_PULSE+H_BACK, H_PULSE+H_BACK+H_ACTIVE) and y_pos in [V_PULSE+V_BACK, V_PULSE+V_BACK+V_ACTIVE).
  - pix_valid = window & locked.
  - pix_x = x_pos-(H_PULSE+H_BACK); pix_y = y_pos-(V_PULSE+V_BACK).
  - All of the above are registered with the counters, i.e. valid in the same cycle as x_pos/y_pos.
- Line check: on line_start with seen_line=1, line_bad = (x_pos+1 != H_TOTAL).
- Lock FSM:
  - SEARCH: on first frame_start_i -> CHECK; good_cnt = 0, frame_bad = 0.
  - CHECK:
    - line_bad sets frame_bad.
    - On frame_start_i, evaluate bad = frame_bad | line_bad | (y_pos+1 != V_TOTAL).
    - If bad: good_cnt = 0. Else: good_cnt += 1, and if it reaches LOCK_FRAMES -> LOCKED.
    - frame_bad is cleared on every frame_start_i.
  - LOCKED:
    - line_bad, or a frame-length mismatch at frame_start_i -> CHECK with good_cnt = 0; sync_err pulses 1 cycle.
    - The mismatching frame counts as bad.
  - Any state: x_pos reaching 1023 (no HSYNC) -> SEARCH; sync_err pulses if the FSM was LOCKED; seen_line = seen_frame = 0.
  - locked is registered: high from the cycle after the transition into LOCKED, low from the cycle after leaving it.
- Boundary cases:
  - frame_start output is the registered frame_start_i (same cycle as y_pos=0).
  - A VSYNC fall mid-line takes effect at the next line_start.
  - If line_bad and frame_start_i occur together, both are evaluated in that cycle.
  - y_pos saturates at 1023 if VSYNC is absent; the frame check then fails on the next VSYNC.

Test Plan:
- Nominal 800x525 generator stream from reset:
  - frame_start pulses every 420000 clocks.
  - locked rises 1 cycle after the third frame_start.
  - h_total_meas=800, v_total_meas=525.
- Pixel mapping, once locked:
  - Generator sample x=144,y=35 -> next cycle pix_valid=1, pix_x=0, pix_y=0.
  - x=783,y=514 -> pix_x=639, pix_y=479.
  - x=784 or y=515 -> pix_valid=0.
- While locked, one line shortened to 799 clocks:
  - At the following line_start: h_total_meas=799, sync_err pulses once, locked drops.
  - Relock occurs after 2 good frames (the damaged frame is not counted).
- HSYNC held high after lock: x_pos saturates at 1023 -> state SEARCH, sync_err pulse, locked=0; restoring HSYNC/VSYNC relocks.
- Frame of 524 lines in CHECK with good_cnt=1: good_cnt resets to 0, v_total_meas=524, no lock that frame.
- reset asserted mid-frame while locked: next cycle all outputs 0, FSM in SEARCH; lock recovers 3 frame_starts later.
